// File: rtl/apb_uart_stream_master_if.sv
// APB3 segment between the stream master (initiator) and a CoreUARTapb-style completer.
// Signals: PADDR/PSEL/PENABLE/PWRITE/PWDATA driven by the master; PRDATA/PREADY/PSLVERR by the slave.
interface apb_uart_stream_master_if;
   logic [4:0] PADDR;
   logic       PSEL;
   logic       PENABLE;
   logic       PWRITE;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_uart_stream_master.sv
// APB3 initiator that configures a CoreUARTapb-style UART, then polls STATUS and moves bytes
// between the UART and a TX byte stream (in) and an RX byte stream (out).
// Ports:
//   PCLK, PRESETN          clock, asynchronous active-low reset
//   apb (master modport)   private APB3 segment to the UART
//   tx_data/tx_valid       byte to send; tx_ready pulses in the cycle the UART accepts it
//   rx_data/rx_valid       received byte, held until rx_ready
//   err_flags, bus_err     sticky UART status errors / APB errors, cleared by err_clr
//   cfg_done               CTRL1 and CTRL2 have been written
module apb_uart_stream_master #(
   parameter logic [12:0] BAUD_VALUE = 13'd1,
   parameter bit          BIT8       = 1'b1,
   parameter bit          PARITY_EN  = 1'b0,
   parameter bit          ODD_N_EVEN = 1'b0,
   parameter int unsigned POLL_GAP   = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                            PCLK,
   input  logic                            PRESETN,
   apb_uart_stream_master_if.master        apb,
   input  logic [7:0]                      tx_data,
   input  logic                            tx_valid,
   output logic                            tx_ready,
   output logic [7:0]                      rx_data,
   output logic                            rx_valid,
   input  logic                            rx_ready,
   output logic [2:0]                      err_flags,
   output logic                            bus_err,
   input  logic                            err_clr,
   output logic                            cfg_done
);

   localparam int unsigned GW = $clog2(POLL_GAP + 2);
   localparam int unsigned TW = $clog2(TIMEOUT + 2);

   localparam logic [4:0] A_TXDATA = 5'h00;
   localparam logic [4:0] A_RXDATA = 5'h04;
   localparam logic [4:0] A_CTRL1  = 5'h08;
   localparam logic [4:0] A_CTRL2  = 5'h0C;
   localparam logic [4:0] A_STATUS = 5'h10;

   localparam logic [7:0] CTRL1_VAL = BAUD_VALUE[7:0];
   localparam logic [7:0] CTRL2_VAL = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};

   typedef enum logic [2:0] {S_CFG1, S_CFG2, S_POLL, S_RXRD, S_TXWR, S_GAP} state_t;
   typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

   state_t          st_q, st_d, ret_q, ret_d, tgt;
   phase_t          ph_q, ph_d;
   logic [GW-1:0]   gcnt_q, gcnt_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [4:0]      paddr_q, paddr_d;
   logic            psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [7:0]      pwdata_q, pwdata_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic [2:0]      err_flags_q, err_flags_d, flags_set;
   logic            bus_err_q, bus_err_d, bus_set;
   logic            cfg_done_q, cfg_done_d;
   logic            start;

   // State and registered outputs
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         st_q        <= S_CFG1;
         ret_q       <= S_POLL;
         ph_q        <= PH_IDLE;
         gcnt_q      <= '0;
         tcnt_q      <= '0;
         paddr_q     <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         err_flags_q <= '0;
         bus_err_q   <= 1'b0;
         cfg_done_q  <= 1'b0;
      end else begin
         st_q        <= st_d;
         ret_q       <= ret_d;
         ph_q        <= ph_d;
         gcnt_q      <= gcnt_d;
         tcnt_q      <= tcnt_d;
         paddr_q     <= paddr_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         err_flags_q <= err_flags_d;
         bus_err_q   <= bus_err_d;
         cfg_done_q  <= cfg_done_d;
      end
   end

   // Next-state: sequencing of transfers, APB phases, stream handshakes and sticky errors
   always_comb begin
      st_d       = st_q;
      ret_d      = ret_q;
      ph_d       = ph_q;
      gcnt_d     = gcnt_q;
      tcnt_d     = tcnt_q;
      paddr_d    = paddr_q;
      psel_d     = psel_q;
      penable_d  = penable_q;
      pwrite_d   = pwrite_q;
      pwdata_d   = pwdata_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      cfg_done_d = cfg_done_q;
      flags_set  = '0;
      bus_set    = 1'b0;
      tx_ready   = 1'b0;
      start      = 1'b0;
      tgt        = (st_q == S_GAP) ? ret_q : st_q;

      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

      case (ph_q)
         // Idle cycle after a transfer; GAP also spends its wait cycles here
         PH_IDLE: begin
            if (st_q != S_GAP) begin
               start = 1'b1;
            end else if (gcnt_q == GW'(POLL_GAP)) begin
               start = 1'b1;
            end else begin
               gcnt_d = gcnt_q + GW'(1);
            end
         end
         PH_SETUP: begin
            ph_d      = PH_ACCESS;
            penable_d = 1'b1;
         end
         PH_ACCESS: begin
            if (apb.PREADY) begin
               ph_d      = PH_IDLE;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               bus_set   = apb.PSLVERR;
               case (st_q)
                  S_CFG1: st_d = S_CFG2;
                  S_CFG2: begin
                     st_d       = S_POLL;
                     cfg_done_d = 1'b1;
                  end
                  S_POLL: begin
                     // An errored STATUS read is treated as all-zero
                     st_d   = S_GAP;
                     ret_d  = S_POLL;
                     gcnt_d = '0;
                     if (!apb.PSLVERR) begin
                        flags_set = apb.PRDATA[4:2];
                        if (apb.PRDATA[1] && !rx_valid_q)    st_d = S_RXRD;
                        else if (apb.PRDATA[0] && tx_valid)  st_d = S_TXWR;
                     end
                  end
                  S_RXRD: begin
                     st_d = S_POLL;
                     if (!apb.PSLVERR) begin
                        rx_data_d  = apb.PRDATA;
                        rx_valid_d = 1'b1;
                     end
                  end
                  S_TXWR: begin
                     st_d     = S_POLL;
                     tx_ready = !apb.PSLVERR;
                  end
                  default: st_d = S_POLL;
               endcase
            end else if ((TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1))) begin
               // Abort a hung completer; configuration writes are retried after the gap
               ph_d      = PH_IDLE;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               bus_set   = 1'b1;
               st_d      = S_GAP;
               gcnt_d    = '0;
               ret_d     = ((st_q == S_CFG1) || (st_q == S_CFG2)) ? st_q : S_POLL;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         default: ph_d = PH_IDLE;
      endcase

      // Launch SETUP of the transfer belonging to tgt
      if (start) begin
         st_d      = tgt;
         ph_d      = PH_SETUP;
         psel_d    = 1'b1;
         penable_d = 1'b0;
         tcnt_d    = '0;
         pwrite_d  = 1'b0;
         pwdata_d  = '0;
         case (tgt)
            S_CFG1: begin
               paddr_d  = A_CTRL1;
               pwrite_d = 1'b1;
               pwdata_d = CTRL1_VAL;
            end
            S_CFG2: begin
               paddr_d  = A_CTRL2;
               pwrite_d = 1'b1;
               pwdata_d = CTRL2_VAL;
            end
            S_RXRD: paddr_d = A_RXDATA;
            S_TXWR: begin
               paddr_d  = A_TXDATA;
               pwrite_d = 1'b1;
               pwdata_d = tx_data;
            end
            default: paddr_d = A_STATUS;
         endcase
      end

      // Sticky bits: a set in the same cycle as err_clr wins
      err_flags_d = flags_set | (err_flags_q & ~{3{err_clr}});
      bus_err_d   = bus_set | (bus_err_q & ~err_clr);
   end

   assign apb.PADDR   = paddr_q;
   assign apb.PSEL    = psel_q;
   assign apb.PENABLE = penable_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PWDATA  = pwdata_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign err_flags   = err_flags_q;
   assign bus_err     = bus_err_q;
   assign cfg_done    = cfg_done_q;

endmodule

// File: tb/tb_apb_uart_stream_master.sv
// Directed bench for apb_uart_stream_master with a small behavioural UART completer.
module tb_apb_uart_stream_master;

   logic       PCLK = 1'b0;
   logic       PRESETN;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [2:0] err_flags;
   logic       bus_err;
   logic       err_clr;
   logic       cfg_done;

   // Completer behaviour knobs
   logic [7:0] status;
   logic [7:0] rxdata;
   logic       stuck;
   logic       err_wr;
   int         wait_tx;
   int         stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic       w;
      logic [4:0] a;
      logic [7:0] d;
      int         cyc;
   } xfer_t;

   xfer_t log_q[$];
   int    cyc;
   int    txr_cnt;
   int    n_unstable;
   int    n_b2b;
   logic       last_done;
   logic [4:0] s_a;
   logic       s_w;
   logic [7:0] s_d;

   apb_uart_stream_master_if apb ();

   apb_uart_stream_master #(
      .BAUD_VALUE (13'h1A5B),
      .BIT8       (1'b1),
      .PARITY_EN  (1'b1),
      .ODD_N_EVEN (1'b0),
      .POLL_GAP   (2),
      .TIMEOUT    (8)
   ) dut (
      .PCLK      (PCLK),
      .PRESETN   (PRESETN),
      .apb       (apb),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .err_flags (err_flags),
      .bus_err   (bus_err),
      .err_clr   (err_clr),
      .cfg_done  (cfg_done)
   );

   always #5 PCLK = ~PCLK;

   // Completer: TXDATA writes may stall wait_tx cycles and may error; stuck blocks every access
   assign apb.PREADY  = apb.PSEL && apb.PENABLE && !stuck &&
                        ((apb.PADDR != 5'h00) || (stall_cnt >= wait_tx));
   assign apb.PSLVERR = apb.PREADY && err_wr && (apb.PADDR == 5'h00);
   assign apb.PRDATA  = (apb.PADDR == 5'h10) ? status :
                        (apb.PADDR == 5'h04) ? rxdata : 8'h00;

   // Bus monitor: transfer log, stability and idle-cycle checks
   always @(posedge PCLK) begin
      cyc <= cyc + 1;
      stall_cnt <= (apb.PSEL && apb.PENABLE && !apb.PREADY) ? stall_cnt + 1 : 0;
      if (tx_ready) txr_cnt <= txr_cnt + 1;
      if (PRESETN) begin
         if (last_done && apb.PSEL) n_b2b <= n_b2b + 1;
         if (apb.PSEL && !apb.PENABLE) begin
            s_a <= apb.PADDR;
            s_w <= apb.PWRITE;
            s_d <= apb.PWDATA;
         end
         if (apb.PSEL && apb.PENABLE &&
             ((apb.PADDR != s_a) || (apb.PWRITE != s_w) || (apb.PWDATA != s_d)))
            n_unstable <= n_unstable + 1;
         if (apb.PSEL && apb.PENABLE && apb.PREADY)
            log_q.push_back('{w: apb.PWRITE, a: apb.PADDR, d: apb.PWDATA, cyc: cyc});
      end
      last_done <= apb.PSEL && apb.PENABLE && apb.PREADY;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   function automatic int count_addr(input logic [4:0] a);
      int n = 0;
      foreach (log_q[i]) if (log_q[i].a == a) n++;
      return n;
   endfunction

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      @(negedge PCLK);
      err_clr = 1'b0;
   endtask

   task automatic pulse_rx_ready();
      rx_ready = 1'b1;
      @(negedge PCLK);
      rx_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int  idx, k, n0, acc, cnt;
      bit  seen;

      cyc = 0; txr_cnt = 0; n_unstable = 0; n_b2b = 0; last_done = 1'b0; stall_cnt = 0;
      s_a = '0; s_w = 1'b0; s_d = '0;
      PRESETN = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
      status = 8'h00; rxdata = 8'h00; stuck = 1'b0; err_wr = 1'b0; wait_tx = 0;

      // Reset state
      cycles(3);
      check_eq("rst_apb", 32'({apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA}), 32'h0);
      check_eq("rst_rx", 32'({rx_valid, rx_data}), 32'h0);
      check_eq("rst_flags", 32'({cfg_done, bus_err, err_flags, tx_ready}), 32'h0);

      // Configuration sequence and poll cadence
      PRESETN = 1'b1;
      for (int i = 0; i < 60 && log_q.size() < 4; i++) @(negedge PCLK);
      check_eq("cfg_xfers_seen", 32'(log_q.size() >= 4), 32'd1);
      if (log_q.size() >= 4) begin
         check_eq("cfg1_wr", 32'({log_q[0].w, log_q[0].a, log_q[0].d}), 32'({1'b1, 5'h08, 8'h5B}));
         check_eq("cfg2_wr", 32'({log_q[1].w, log_q[1].a, log_q[1].d}), 32'({1'b1, 5'h0C, 8'hD3}));
         check_eq("poll_rd", 32'({log_q[2].w, log_q[2].a}), 32'({1'b0, 5'h10}));
         check_eq("cfg_spacing", 32'(log_q[1].cyc - log_q[0].cyc), 32'd3);
         check_eq("poll_period", 32'(log_q[3].cyc - log_q[2].cyc), 32'd5);
      end
      check_eq("cfg_done", 32'(cfg_done), 32'd1);

      // RX path: one-entry slot blocks further RXDATA reads
      status = 8'h02; rxdata = 8'hA5;
      for (int i = 0; i < 40 && !rx_valid; i++) @(negedge PCLK);
      check_eq("rx_valid", 32'(rx_valid), 32'd1);
      check_eq("rx_data", 32'(rx_data), 32'hA5);
      n0 = count_addr(5'h04);
      cycles(30);
      check_eq("rx_hold_no_read", 32'(count_addr(5'h04)), 32'(n0));
      check_eq("rx_hold_valid", 32'(rx_valid), 32'd1);
      pulse_rx_ready();
      check_eq("rx_clear", 32'(rx_valid), 32'd0);
      rxdata = 8'h96;
      for (int i = 0; i < 40 && !rx_valid; i++) @(negedge PCLK);
      check_eq("rx_reread", 32'({rx_valid, rx_data}), 32'h196);
      status = 8'h00;
      cycles(6);
      pulse_rx_ready();

      // RX has priority over TX
      idx = log_q.size(); n0 = txr_cnt;
      status = 8'h03; rxdata = 8'h5A; tx_data = 8'h3C; tx_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge PCLK);
         if (tx_ready) begin seen = 1'b1; break; end
      end
      check_eq("prio_tx_seen", 32'(seen), 32'd1);
      @(posedge PCLK); #1 tx_valid = 1'b0;
      k = -1;
      for (int i = idx; i < log_q.size(); i++) if (k < 0 && log_q[i].a == 5'h04) k = i;
      check_eq("prio_rxrd_found", 32'(k >= 0 && k + 2 < log_q.size()), 32'd1);
      if (k >= 0 && k + 2 < log_q.size()) begin
         check_eq("prio_poll_after_rx", 32'({log_q[k+1].w, log_q[k+1].a}), 32'({1'b0, 5'h10}));
         check_eq("prio_txwr", 32'({log_q[k+2].w, log_q[k+2].a, log_q[k+2].d}), 32'({1'b1, 5'h00, 8'h3C}));
      end
      check_eq("prio_rx_data", 32'(rx_data), 32'h5A);
      status = 8'h00;
      cycles(20);
      check_eq("tx_single_pulse", 32'(txr_cnt - n0), 32'd1);
      pulse_rx_ready();

      // Wait states on TXDATA write
      wait_tx = 3; status = 8'h01; tx_data = 8'hC3; tx_valid = 1'b1;
      acc = 0; seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge PCLK);
         if (apb.PSEL && apb.PENABLE && apb.PADDR == 5'h00) acc++;
         if (tx_ready) begin seen = 1'b1; break; end
      end
      check_eq("ws_tx_seen", 32'(seen), 32'd1);
      check_eq("ws_access_len", 32'(acc), 32'd4);
      check_eq("ws_pwdata", 32'(apb.PWDATA), 32'hC3);
      @(posedge PCLK); #1 tx_valid = 1'b0; wait_tx = 0; status = 8'h00;

      // PSLVERR on TXDATA write, then retry and err_clr
      err_wr = 1'b1; status = 8'h01; tx_data = 8'h77; tx_valid = 1'b1; seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge PCLK);
         if (apb.PSEL && apb.PENABLE && apb.PREADY && apb.PADDR == 5'h00) begin seen = 1'b1; break; end
      end
      check_eq("slverr_hit", 32'(seen), 32'd1);
      check_eq("slverr_no_txready", 32'(tx_ready), 32'd0);
      @(negedge PCLK);
      check_eq("slverr_bus_err", 32'(bus_err), 32'd1);
      err_wr = 1'b0; seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge PCLK);
         if (tx_ready) begin seen = 1'b1; break; end
      end
      check_eq("tx_retry", 32'(seen), 32'd1);
      check_eq("tx_retry_data", 32'(apb.PWDATA), 32'h77);
      @(posedge PCLK); #1 tx_valid = 1'b0; status = 8'h00;
      @(negedge PCLK);
      pulse_err_clr();
      check_eq("bus_err_clr", 32'(bus_err), 32'd0);

      // Sticky STATUS error flags
      status = 8'h14;
      cycles(12);
      check_eq("err_flags_set", 32'(err_flags), 32'h5);
      status = 8'h00;
      cycles(12);
      check_eq("err_flags_sticky", 32'(err_flags), 32'h5);
      pulse_err_clr();
      check_eq("err_flags_clr", 32'(err_flags), 32'h0);
      status = 8'h04; err_clr = 1'b1; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK);
         if (apb.PSEL && apb.PENABLE && apb.PREADY && apb.PADDR == 5'h10) begin seen = 1'b1; break; end
      end
      @(negedge PCLK);
      check_eq("errclr_set_wins", 32'({seen, err_flags}), 32'({1'b1, 3'b001}));
      err_clr = 1'b0; status = 8'h00;
      cycles(2);
      pulse_err_clr();

      // PREADY timeout on a poll
      stuck = 1'b1;
      for (int i = 0; i < 20 && !(apb.PSEL && apb.PENABLE); i++) @(negedge PCLK);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (!apb.PENABLE) break;
         cnt++;
         @(negedge PCLK);
      end
      check_eq("timeout_len", 32'(cnt), 32'd8);
      check_eq("timeout_psel", 32'(apb.PSEL), 32'd0);
      check_eq("timeout_bus_err", 32'(bus_err), 32'd1);
      stuck = 1'b0;
      n0 = log_q.size();
      cycles(20);
      check_eq("poll_resume", 32'(log_q.size() > n0), 32'd1);
      pulse_err_clr();

      // Reset mid-transfer, then a CFG1 timeout retried after the gap
      for (int i = 0; i < 20 && !apb.PSEL; i++) @(negedge PCLK);
      #1 PRESETN = 1'b0; stuck = 1'b1;
      #1 check_eq("async_rst_psel", 32'({apb.PSEL, apb.PENABLE, cfg_done}), 32'h0);
      @(negedge PCLK);
      PRESETN = 1'b1; idx = log_q.size();
      for (int i = 0; i < 40 && !bus_err; i++) @(negedge PCLK);
      check_eq("cfg_timeout_bus_err", 32'(bus_err), 32'd1);
      stuck = 1'b0;
      for (int i = 0; i < 40 && log_q.size() <= idx; i++) @(negedge PCLK);
      check_eq("cfg_retry_seen", 32'(log_q.size() > idx), 32'd1);
      if (log_q.size() > idx)
         check_eq("cfg1_retry", 32'({log_q[idx].w, log_q[idx].a, log_q[idx].d}), 32'({1'b1, 5'h08, 8'h5B}));
      for (int i = 0; i < 40 && !cfg_done; i++) @(negedge PCLK);
      check_eq("cfg_done_after_retry", 32'(cfg_done), 32'd1);

      check_eq("apb_stable", 32'(n_unstable), 32'd0);
      check_eq("idle_after_xfer", 32'(n_b2b), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
